// File: rtl/fetch_sequencer_if.sv
// Bundle of the redirect, downstream and instruction-memory signals of the
// fetch sequencer. The sequencer takes the slave view; the surrounding
// pipeline and memory take the master view.
interface fetch_sequencer_if;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;

  modport slave (
    input  branch, jal, jalr, branch_target, jal_target, jalr_target,
    input  stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc
  );

  modport master (
    output branch, jal, jalr, branch_target, jal_target, jalr_target,
    output stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | just out of reset, first request issued on the next edge
// REQ     | request on the bus at imem_addr, waiting for imem_ack
// VALID   | fetched word presented, waiting for consumption (stall=0)
// DISCARD | redirected while a request was outstanding; the old request
//         | is completed on the bus and its data thrown away
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_DISCARD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  // Redirect select: branch beats jal beats jalr, target taken unaligned as-is.
  always_comb begin
    w_redir  = bus.branch | bus.jal | bus.jalr;
    w_target = bus.jalr_target;
    if (bus.branch)
      w_target = bus.branch_target;
    else if (bus.jal)
      w_target = bus.jal_target;
  end

  // Natural 32-bit overflow gives the required wrap at 32'hFFFF_FFFC.
  assign w_pc_inc = r_pc + 32'd4;

  // Fetch FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= 32'h0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A late ack from a request abandoned by reset is ignored here.
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
          if (w_redir) begin
            r_pc        <= w_target;
            r_imem_addr <= w_target;
          end else begin
            r_imem_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            if (w_redir) begin
              // Data belongs to the old path: drop it and refetch at once.
              r_pc        <= w_target;
              r_imem_addr <= w_target;
            end else begin
              r_instr       <= bus.imem_rdata;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= w_pc_inc;
              r_imem_req    <= 1'b0;
              r_state       <= S_VALID;
            end
          end else if (w_redir) begin
            // Bus request must stay stable, so finish it in DISCARD.
            r_pc    <= w_target;
            r_state <= S_DISCARD;
          end
        end
        S_VALID: begin
          if (w_redir) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= w_target;
            r_state       <= S_REQ;
          end else if (!bus.stall) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= r_pc;
            r_state       <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (bus.imem_ack) begin
            r_state <= S_REQ;
            if (w_redir) begin
              r_pc        <= w_target;
              r_imem_addr <= w_target;
            end else begin
              r_imem_addr <= r_pc;
            end
          end else if (w_redir) begin
            r_pc <= w_target;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.pc          = r_pc;

endmodule
